// File: rtl/if_id_queue.sv
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : In-order packet queue between IF and ID. It absorbs ID stalls,
//             and a flush drops its whole contents. The IF_ID_QUEUE_BYPASS_EN
//             macro forwards input straight to the output when the queue is
//             empty.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 66,
  parameter int EXC_W  = 4,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_except,
  output logic              in_allowin,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_except,
  input  logic              out_allowin,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [EXC_W-1:0]  r_exc  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_nonempty;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;

  assign w_nonempty = (r_cnt != '0);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass = ~w_nonempty & in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed packet that ID accepts immediately never touches storage.
  assign w_bypass_take = w_bypass & out_allowin;

  // in_allowin depends only on registered occupancy, never on out_allowin.
  assign in_allowin = (r_cnt != c_DEPTH);
  assign out_valid  = (w_nonempty & ~flush) | w_bypass;
  assign out_data   = w_bypass ? in_data   : r_data[r_rd_ptr];
  assign out_except = w_bypass ? in_except : r_exc[r_rd_ptr];
  assign count      = r_cnt;

  assign w_push = in_valid & in_allowin & ~flush & ~w_bypass_take;
  assign w_pop  = w_nonempty & ~flush & out_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_exc[i]  <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= in_data;
        r_exc[r_wr_ptr]  <= in_except;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Self-checking bench for if_id_queue. It applies a vector table,
//             a few directed sequences and random traffic checked against a
//             queue model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 66;
  localparam int EXC_W  = 4;
  localparam int CNT_W  = 3;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_except;
  logic              in_allowin;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_except;
  logic              out_allowin;
  logic              flush;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .EXC_W(EXC_W), .PTR_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_except(in_except),
    .in_allowin(in_allowin), .out_valid(out_valid), .out_data(out_data),
    .out_except(out_except), .out_allowin(out_allowin), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Packet layout: {valid, pc, IR, predict}; IR is derived from pc for variety.
  function automatic logic [DATA_W-1:0] pkt(input logic [31:0] pc);
    return {1'b1, pc, pc ^ 32'h5a5a_0f0f, pc[2]};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an unbounded list trimmed by the queue's capacity rules.
  logic [EXC_W+DATA_W-1:0] mq[$];

  // One clock cycle driven from posedge+1; combinational outputs are checked mid-cycle.
  task automatic mcyc(input bit iv, input bit oa, input bit fl,
                      input logic [31:0] pc, input logic [EXC_W-1:0] ex);
    bit full, byp, ov;
    logic [EXC_W+DATA_W-1:0] head;
    in_valid = iv; out_allowin = oa; flush = fl; in_data = pkt(pc); in_except = ex;
    #4;
    full = (mq.size() == DEPTH);
    byp  = BYP && (mq.size() == 0) && iv && !fl;
    ov   = ((mq.size() != 0) && !fl) || byp;
    head = byp ? {ex, pkt(pc)} : (mq.size() != 0 ? mq[0] : '0);
    chk("m_in_allowin", DATA_W'(in_allowin), DATA_W'(!full));
    chk("m_out_valid", DATA_W'(out_valid), DATA_W'(ov));
    if (ov) begin
      chk("m_out_data", out_data, head[DATA_W-1:0]);
      chk("m_out_except", DATA_W'(out_except), DATA_W'(head[EXC_W+DATA_W-1:DATA_W]));
    end
    if (fl) mq.delete();
    else begin
      if (byp && oa) begin
        // consumed directly, never stored
      end else begin
        if (ov && oa) void'(mq.pop_front());
        if (iv && !full) mq.push_back({ex, pkt(pc)});
      end
    end
    @(posedge clk); #1;
    chk("m_count", DATA_W'(count), DATA_W'(mq.size()));
  endtask

  typedef struct {
    bit              iv, oa, fl;
    logic [31:0]     pc;
    logic [EXC_W-1:0] ex;
    bit              e_ov;
    logic [31:0]     e_pc;
    logic [EXC_W-1:0] e_ex;
    bit              e_ia;
    int              e_cnt;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] pc;
    vt[0]  = '{1,0,0, 32'h1c000000, 4'h0, BYP, 32'h1c000000, 4'h0, 1, 1};
    vt[1]  = '{1,0,0, 32'h1c000004, 4'h0, 1,   32'h1c000000, 4'h0, 1, 2};
    vt[2]  = '{1,0,0, 32'h1c000008, 4'h0, 1,   32'h1c000000, 4'h0, 1, 3};
    vt[3]  = '{1,0,0, 32'h1c00000c, 4'h0, 1,   32'h1c000000, 4'h0, 1, 4};
    vt[4]  = '{1,1,0, 32'h1c000010, 4'h0, 1,   32'h1c000000, 4'h0, 0, 3};
    vt[5]  = '{1,0,0, 32'h1c000010, 4'h0, 1,   32'h1c000004, 4'h0, 1, 4};
    vt[6]  = '{0,1,0, 32'h1c000014, 4'h0, 1,   32'h1c000004, 4'h0, 0, 3};
    vt[7]  = '{1,1,0, 32'h1c000018, 4'h0, 1,   32'h1c000008, 4'h0, 1, 3};
    vt[8]  = '{1,1,1, 32'h1c000020, 4'h0, 0,   32'h0,        4'h0, 1, 0};
    vt[9]  = '{0,1,0, 32'h1c000024, 4'h0, 0,   32'h0,        4'h0, 1, 0};
    vt[10] = '{1,0,0, 32'h1c000001, 4'h8, BYP, 32'h1c000001, 4'h8, 1, 1};
    vt[11] = '{0,1,0, 32'h1c000028, 4'h0, 1,   32'h1c000001, 4'h8, 1, 0};

    rst = 1'b1; in_valid = 0; out_allowin = 0; flush = 0; in_data = '0; in_except = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_except", DATA_W'(out_except), '0);
    chk("rst_in_allowin", DATA_W'(in_allowin), DATA_W'(1));
    chk("rst_count", DATA_W'(count), '0);
    @(posedge clk); #1;

    // Directed vector table: fill, full-with-pop, flush, exception tag, bypass.
    for (int i = 0; i < 12; i++) begin
      in_valid = vt[i].iv; out_allowin = vt[i].oa; flush = vt[i].fl;
      in_data = pkt(vt[i].pc); in_except = vt[i].ex;
      #4;
      chk($sformatf("v%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(vt[i].e_ov));
      chk($sformatf("v%0d_in_allowin", i), DATA_W'(in_allowin), DATA_W'(vt[i].e_ia));
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_pc", i), DATA_W'(out_data[64:33]), DATA_W'(vt[i].e_pc));
        chk($sformatf("v%0d_except", i), DATA_W'(out_except), DATA_W'(vt[i].e_ex));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), DATA_W'(count), DATA_W'(vt[i].e_cnt));
    end
    mq.delete();

    // Steady stream: 20 cycles push+pop, pointers wrap several times.
    pc = 32'h1c001000;
    for (int i = 0; i < 20; i++) begin
      mcyc(1, 1, 0, pc, 4'(i));
      pc = pc + 32'd4;
    end
    mcyc(0, 1, 0, pc, 4'h0);

    // Reset mid-operation overrides push, pop and a queued backlog.
    for (int i = 0; i < 3; i++) begin
      mcyc(1, 0, 0, pc, 4'h3);
      pc = pc + 32'd4;
    end
    rst = 1'b1; in_valid = 1; out_allowin = 1; flush = 1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 0; out_allowin = 0; flush = 0;
    mq.delete();
    #3;
    chk("mrst_count", DATA_W'(count), '0);
    chk("mrst_in_allowin", DATA_W'(in_allowin), DATA_W'(1));
    chk("mrst_out_valid", DATA_W'(out_valid), '0);
    chk("mrst_out_data", out_data, '0);
    chk("mrst_out_except", DATA_W'(out_except), '0);
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mcyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, pc, 4'($urandom_range(0, 15)));
      pc = pc + 32'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
